// File: rtl/eh2_mem_shared_dccm.sv
// Shared word-interleaved DCCM: NUM_CORES request ports over NUM_BANKS banks, each bank
// with its own round-robin arbiter, plus saturating per-core bank-conflict stall counters.
module eh2_mem_shared_dccm #(
   parameter  int NUM_CORES  = 2,
   parameter  int NUM_BANKS  = 4,
   parameter  int BANK_DEPTH = 1024,
   parameter  int DATA_WIDTH = 39,
   parameter  int CNT_WIDTH  = 16,
   localparam int AW         = $clog2(NUM_BANKS) + $clog2(BANK_DEPTH)
) (
   input  logic                                  clk,
   input  logic                                  rst_l,
   input  logic [NUM_CORES-1:0]                  req_valid,
   input  logic [NUM_CORES-1:0]                  req_wr,
   input  logic [NUM_CORES-1:0][AW-1:0]          req_addr,
   input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_CORES-1:0]                  req_ready,
   output logic [NUM_CORES-1:0]                  rsp_valid,
   output logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  rsp_rdata,
   output logic [NUM_CORES-1:0][CNT_WIDTH-1:0]   stall_cnt,
   input  logic                                  stall_cnt_clr
);

   localparam int BSW = $clog2(NUM_BANKS);
   localparam int RW  = $clog2(BANK_DEPTH);
   localparam int BIW = (BSW > 0) ? BSW : 1;
   localparam int RIW = (RW > 0) ? RW : 1;
   localparam int PW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   logic [NUM_CORES-1:0][BIW-1:0] bank_of;
   logic [NUM_CORES-1:0][RIW-1:0] row_of;
   logic [NUM_BANKS-1:0][PW-1:0]  rr_ptr;
   logic [NUM_BANKS-1:0][PW-1:0]  rr_nxt;
   logic [NUM_BANKS-1:0][PW-1:0]  bank_win;
   logic [NUM_BANKS-1:0]          bank_hit;
   logic [DATA_WIDTH-1:0]         mem [NUM_BANKS][BANK_DEPTH];

   // Low-order interleave: the mask collapses to zero when there is a single bank.
   always_comb begin
      for (int c = 0; c < NUM_CORES; c++) begin
         bank_of[c] = BIW'(req_addr[c] & AW'(NUM_BANKS - 1));
         row_of[c]  = RIW'(req_addr[c] >> BSW);
      end
   end

   always_comb begin
      bank_hit  = '0;
      bank_win  = '0;
      rr_nxt    = rr_ptr;
      req_ready = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            int idx;
            idx = (int'(rr_ptr[b]) + k) % NUM_CORES;
            if (rst_l && !bank_hit[b] && req_valid[idx] && (int'(bank_of[idx]) == b)) begin
               bank_hit[b]    = 1'b1;
               bank_win[b]    = PW'(idx);
               rr_nxt[b]      = PW'((idx + 1) % NUM_CORES);
               req_ready[idx] = 1'b1;
            end
         end
      end
   end

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_hit[b] && req_wr[bank_win[b]]) begin
            mem[b][row_of[bank_win[b]]] <= req_wdata[bank_win[b]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rr_ptr <= '0;
      end else begin
         rr_ptr <= rr_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         for (int c = 0; c < NUM_CORES; c++) begin
            rsp_valid[c] <= req_ready[c] & ~req_wr[c];
            if (req_ready[c] && !req_wr[c]) begin
               rsp_rdata[c] <= mem[bank_of[c]][row_of[c]];
            end
         end
      end
   end

   // Clear takes priority over a same-cycle stall; counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         stall_cnt <= '0;
      end else begin
         for (int c = 0; c < NUM_CORES; c++) begin
            if (stall_cnt_clr) begin
               stall_cnt[c] <= '0;
            end else if (req_valid[c] && !req_ready[c] && (stall_cnt[c] != '1)) begin
               stall_cnt[c] <= stall_cnt[c] + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule
